// File: rtl/accel_pkg.sv
// accel_pkg: types and constants shared by the MAC pipeline and its drain
// controller.
//   ACC_W_DEF / OUT_W_DEF : default accumulator / requantized result widths
//   drain_state_t         : mac_drain FSM states
//   SAT_MAX / SAT_MIN     : saturation limits for an OUT_W_DEF-bit result
package accel_pkg;

  localparam int ACC_W_DEF = 32;
  localparam int OUT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COUNT,
    DRAIN,
    CAPTURE
  } drain_state_t;

  localparam logic signed [OUT_W_DEF-1:0] SAT_MAX = {1'b0, {(OUT_W_DEF-1){1'b1}}};
  localparam logic signed [OUT_W_DEF-1:0] SAT_MIN = {1'b1, {(OUT_W_DEF-1){1'b0}}};

endpackage

// File: rtl/mac_drain_fifo.sv
// mac_drain_fifo: DEPTH x W synchronous FIFO holding requantized results.
//   clk, rst     : clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata  : write request and data; ignored while full
//   pop          : read request; ignored while empty
//   rdata        : head entry (driven from registers only)
//   full, empty  : registered status flags
module mac_drain_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_n;
  logic          do_push, do_pop;

  // Push is gated by the registered full flag, so a pop on a full FIFO frees
  // the slot only for the following cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_n = count;
    if (do_push && !do_pop) count_n = count + (AW+1)'(1);
    else if (do_pop && !do_push) count_n = count - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      full  <= (count_n == (AW+1)'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/mac_drain.sv
// mac_drain: frames one dot-product job on a MAC core, then requantizes the
// accumulator and queues the result behind a valid/ready port.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : job start pulse (IDLE only); len/shift/relu_en latched
//   mac_en_in       : MAC enable strobe, one beat per high cycle
//   acc_in          : signed MAC accumulator
//   mac_clr         : one-cycle clear pulse to the MAC
//   busy            : FSM not in IDLE
//   out_data/valid  : FIFO head, ready handshake with out_ready
//   sat_flag        : sticky saturation indicator for the current job
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | mac_clr pulse
// COUNT   | counting MAC beats up to len
// DRAIN   | waiting PIPE_LAT cycles for the pipeline to flush
// CAPTURE | requantize acc_in and push; holds while the FIFO is full
module mac_drain
  import accel_pkg::*;
#(
  parameter int ACC_W    = ACC_W_DEF,
  parameter int OUT_W    = OUT_W_DEF,
  parameter int LEN_W    = 16,
  parameter int PIPE_LAT = 4,
  parameter int DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic [4:0]              shift,
  input  logic                    relu_en,
  input  logic                    mac_en_in,
  input  logic signed [ACC_W-1:0] acc_in,
  output logic                    mac_clr,
  output logic                    busy,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sat_flag
);

  localparam int WCNT_W = $clog2(PIPE_LAT + 1);

  localparam logic signed [ACC_W:0] GEN_HI = $signed({{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] GEN_LO = $signed({{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});
  localparam logic signed [ACC_W:0] SAT_HI = (OUT_W == OUT_W_DEF) ? (ACC_W+1)'(SAT_MAX) : GEN_HI;
  localparam logic signed [ACC_W:0] SAT_LO = (OUT_W == OUT_W_DEF) ? (ACC_W+1)'(SAT_MIN) : GEN_LO;

  drain_state_t state_q, state_d;

  logic [LEN_W-1:0]  len_q, bcnt_q;
  logic [4:0]        shift_q;
  logic              relu_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              push, fifo_full, fifo_empty;

  logic signed [ACC_W:0]   acc_x, rnd, sum, shr;
  logic signed [OUT_W-1:0] res;
  logic                    clamp;

  // Requantizer: round-half-up arithmetic shift in ACC_W+1 bits so the
  // rounding add cannot overflow, then optional ReLU and saturation.
  always_comb begin
    acc_x = {acc_in[ACC_W-1], acc_in};
    rnd   = '0;
    if (shift_q != 5'd0) rnd[shift_q - 5'd1] = 1'b1;
    sum   = acc_x + rnd;
    shr   = sum >>> shift_q;
    if (relu_q && shr < 0) shr = '0;
    clamp = 1'b0;
    if (shr > SAT_HI) begin
      res   = SAT_HI[OUT_W-1:0];
      clamp = 1'b1;
    end else if (shr < SAT_LO) begin
      res   = SAT_LO[OUT_W-1:0];
      clamp = 1'b1;
    end else begin
      res = shr[OUT_W-1:0];
    end
    if (len_q == '0) begin
      res   = '0;
      clamp = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    mac_clr = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR: begin
        mac_clr = 1'b1;
        state_d = (len_q == '0) ? DRAIN : COUNT;
      end
      COUNT:   if (mac_en_in && bcnt_q == len_q - LEN_W'(1)) state_d = DRAIN;
      DRAIN:   if (wcnt_q == '0) state_d = CAPTURE;
      CAPTURE: begin
        if (!fifo_full) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      bcnt_q   <= '0;
      wcnt_q   <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        len_q    <= len;
        shift_q  <= shift;
        relu_q   <= relu_en;
        bcnt_q   <= '0;
        sat_flag <= 1'b0;
      end
      if (state_q == COUNT && mac_en_in) bcnt_q <= bcnt_q + LEN_W'(1);
      // Drain timer: loaded on entry, terminal count at zero.
      if (state_d == DRAIN && state_q != DRAIN) wcnt_q <= WCNT_W'(PIPE_LAT - 1);
      else if (state_q == DRAIN && wcnt_q != '0) wcnt_q <= wcnt_q - WCNT_W'(1);
      if (push && clamp) sat_flag <= 1'b1;
    end
  end

  mac_drain_fifo #(
    .DEPTH (DEPTH),
    .W     (OUT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (res),
    .pop   (out_ready),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mac_drain.sv
module tb_mac_drain;

  localparam int PIPE_LAT = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [15:0]        len;
  logic [4:0]         shift;
  logic               relu_en;
  logic               mac_en_in;
  logic signed [31:0] acc_in;
  logic               mac_clr;
  logic               busy;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               sat_flag;

  int checks     = 0;
  int failures   = 0;
  int clr_pulses = 0;

  mac_drain #(
    .ACC_W    (32),
    .OUT_W    (16),
    .LEN_W    (16),
    .PIPE_LAT (PIPE_LAT),
    .DEPTH    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .shift     (shift),
    .relu_en   (relu_en),
    .mac_en_in (mac_en_in),
    .acc_in    (acc_in),
    .mac_clr   (mac_clr),
    .busy      (busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mac_clr) clr_pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [15:0]        len;
    logic [4:0]         sh;
    logic               relu;
    logic signed [31:0] acc;
    logic signed [15:0] exp_d;
    logic               exp_sat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [15:0] l, input logic [4:0] s, input logic r);
    start = 1'b1; len = l; shift = s; relu_en = r;
    @(negedge clk);
    start = 1'b0;
    chk("clear_pulse", longint'(mac_clr), 1);
    chk("clear_busy", longint'(busy), 1);
    chk("start_clears_sat", longint'(sat_flag), 0);
    @(negedge clk);
  endtask

  task automatic beats(input logic [15:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      mac_en_in = mask[i];
      @(negedge clk);
    end
    mac_en_in = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: out_valid still 0 after %0d cycles", nm, n);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: busy still 1 after %0d cycles", nm, n);
    end
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;

    vecs[0]  = '{16'd3, 5'd4,  1'b0, 32'sd1000,        16'sd63,     1'b0};
    vecs[1]  = '{16'd3, 5'd4,  1'b0, -32'sd1000,       -16'sd62,    1'b0};
    vecs[2]  = '{16'd3, 5'd4,  1'b1, -32'sd1000,       16'sd0,      1'b0};
    vecs[3]  = '{16'd2, 5'd0,  1'b0, 32'sd1048576,     16'sd32767,  1'b1};
    vecs[4]  = '{16'd1, 5'd0,  1'b0, 32'sh80000000,    -16'sd32768, 1'b1};
    vecs[5]  = '{16'd2, 5'd1,  1'b0, 32'sd3,           16'sd2,      1'b0};
    vecs[6]  = '{16'd1, 5'd1,  1'b0, -32'sd3,          -16'sd1,     1'b0};
    vecs[7]  = '{16'd1, 5'd8,  1'b0, 32'sd8388479,     16'sd32767,  1'b0};
    vecs[8]  = '{16'd1, 5'd8,  1'b0, 32'sd8388480,     16'sd32767,  1'b1};
    vecs[9]  = '{16'd1, 5'd31, 1'b0, 32'sh80000000,    -16'sd1,     1'b0};
    vecs[10] = '{16'd1, 5'd31, 1'b0, 32'sh7FFFFFFF,    16'sd1,      1'b0};
    vecs[11] = '{16'd1, 5'd0,  1'b1, -32'sd5,          16'sd0,      1'b0};

    rst = 1'b1; start = 1'b0; len = '0; shift = '0; relu_en = 1'b0;
    mac_en_in = 1'b0; acc_in = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_mac_clr", longint'(mac_clr), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sat_flag", longint'(sat_flag), 0);
    rst = 1'b0;
    @(negedge clk);

    // Requantization table
    for (int i = 0; i < 12; i++) begin
      acc_in = vecs[i].acc;
      launch(vecs[i].len, vecs[i].sh, vecs[i].relu);
      beats(16'hFFFF, int'(vecs[i].len));
      wait_valid("vec_valid", n);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_d);
      chk($sformatf("vec%0d_sat", i), longint'(sat_flag), longint'(vecs[i].exp_sat));
      chk($sformatf("vec%0d_idle", i), longint'(busy), 0);
      pop_one();
      chk($sformatf("vec%0d_popped", i), longint'(out_valid), 0);
    end

    // Framing: gapped beats, stray start while busy, capture latency
    acc_in = 32'sd777;
    clr_pulses = 0;
    launch(16'd5, 5'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      mac_en_in = (i != 1 && i != 4);
      start     = (i == 2);
      len       = 16'd2;
      @(negedge clk);
    end
    mac_en_in = 1'b0;
    start     = 1'b0;
    wait_valid("frame_valid", n);
    chk("frame_latency", n, PIPE_LAT + 1);
    chk("frame_data", out_data, 777);
    chk("frame_clr_pulses", clr_pulses, 1);
    pop_one();
    repeat (2) @(negedge clk);
    chk("frame_no_restart", longint'(busy), 0);
    chk("frame_single_result", longint'(out_valid), 0);

    // len == 0: beats ignored, result forced to zero
    acc_in = 32'sd12345;
    mac_en_in = 1'b1;
    launch(16'd0, 5'd3, 1'b0);
    wait_valid("len0_valid", n);
    mac_en_in = 1'b0;
    chk("len0_latency", n, PIPE_LAT + 1);
    chk("len0_data", out_data, 0);
    chk("len0_sat", longint'(sat_flag), 0);
    pop_one();

    // Backpressure: four buffered, fifth stalls in CAPTURE
    out_ready = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      acc_in = j;
      launch(16'd1, 5'd0, 1'b0);
      beats(16'h1, 1);
      wait_idle("bp_job");
    end
    chk("bp_valid", longint'(out_valid), 1);
    chk("bp_head", out_data, 1);
    acc_in = 32'sd5;
    launch(16'd1, 5'd0, 1'b0);
    beats(16'h1, 1);
    repeat (8) @(negedge clk);
    chk("bp_stall_busy", longint'(busy), 1);
    chk("bp_stall_head", out_data, 1);
    out_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      wait_valid("bp_drain", n);
      chk($sformatf("bp_order%0d", j), out_data, j);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("bp_empty", longint'(out_valid), 0);
    chk("bp_idle", longint'(busy), 0);

    // Reset mid-COUNT with two results queued
    acc_in = 32'sd7;
    launch(16'd1, 5'd0, 1'b0);
    beats(16'h1, 1);
    wait_idle("rst_q1");
    acc_in = 32'sd8;
    launch(16'd1, 5'd0, 1'b0);
    beats(16'h1, 1);
    wait_idle("rst_q2");
    chk("rst_queued", longint'(out_valid), 1);
    acc_in = 32'sd99;
    launch(16'd8, 5'd0, 1'b0);
    beats(16'h3, 2);
    chk("rst_in_count", longint'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", longint'(out_valid), 0);
    chk("rst_mid_busy", longint'(busy), 0);
    chk("rst_mid_clr", longint'(mac_clr), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after_valid", longint'(out_valid), 0);
    acc_in = 32'sd9;
    launch(16'd1, 5'd0, 1'b0);
    beats(16'h1, 1);
    wait_valid("post_rst_valid", n);
    chk("post_rst_data", out_data, 9);
    pop_one();
    chk("post_rst_empty", longint'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
